// File: rtl/draw_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : draw_cmd_dispatcher
// Brief    : Assembles 3-word draw commands into line/circle engine operands.
// Revision : 1.0
// ============================================================================
module draw_cmd_dispatcher #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [31:0]      cmd_data,
    input  logic             cmd_rts,
    output logic             cmd_rtr,
    output logic [51:0]      line_op,
    output logic             line_rts,
    input  logic             line_rtr,
    output logic [41:0]      circle_op,
    output logic             circle_rts,
    input  logic             circle_rtr,
    output logic             busy,
    output logic [ERR_W-1:0] bad_cmd_cnt
);

    typedef enum logic [1:0] {
        S_HDR   = 2'd0,
        S_ARG1  = 2'd1,
        S_ARG2  = 2'd2,
        S_ISSUE = 2'd3
    } state_t;

    localparam logic [ERR_W-1:0] c_ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_is_circle;
    logic [11:0] r_color;
    logic [9:0]  r_xa;
    logic [9:0]  r_ya;
    logic [3:0]  w_opcode;
    logic        w_xfer;
    logic        w_handoff;
    logic        w_unused_bits;

    assign w_opcode      = cmd_data[31:28];
    assign w_unused_bits = ^{cmd_data[27:26], cmd_data[15:12]};

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_rtr     = 1'b1;
        busy        = 1'b1;
        line_rts    = 1'b0;
        circle_rts  = 1'b0;
        w_xfer      = 1'b0;
        w_handoff   = 1'b0;
        case (r_state)
            S_HDR: begin
                busy   = 1'b0;
                w_xfer = cmd_rts;
                if (w_xfer && (w_opcode == 4'd1 || w_opcode == 4'd2)) begin
                    w_state_nxt = S_ARG1;
                end
            end
            S_ARG1: begin
                w_xfer = cmd_rts;
                if (w_xfer) begin
                    w_state_nxt = S_ARG2;
                end
            end
            S_ARG2: begin
                w_xfer = cmd_rts;
                if (w_xfer) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            default: begin
                cmd_rtr    = 1'b0;
                line_rts   = !r_is_circle;
                circle_rts = r_is_circle;
                w_handoff  = r_is_circle ? circle_rtr : line_rtr;
                if (w_handoff) begin
                    w_state_nxt = S_HDR;
                end
            end
        endcase
    end

    // Operand registers load only on the ARG2 transfer, so they stay frozen
    // for the whole time the matching rts is asserted.
    always_ff @(posedge clk) begin
        if (rst_) begin
            r_is_circle <= 1'b0;
            r_color     <= 12'd0;
            r_xa        <= 10'd0;
            r_ya        <= 10'd0;
            line_op     <= 52'd0;
            circle_op   <= 42'd0;
            bad_cmd_cnt <= '0;
        end else if (w_xfer) begin
            case (r_state)
                S_HDR: begin
                    if (w_opcode == 4'd1 || w_opcode == 4'd2) begin
                        r_is_circle <= (w_opcode == 4'd2);
                        r_color     <= cmd_data[11:0];
                    end else if (w_opcode != 4'd0 && bad_cmd_cnt != '1) begin
                        bad_cmd_cnt <= bad_cmd_cnt + c_ERR_ONE;
                    end
                end
                S_ARG1: begin
                    r_xa <= cmd_data[25:16];
                    r_ya <= cmd_data[9:0];
                end
                S_ARG2: begin
                    if (r_is_circle) begin
                        circle_op <= {r_xa, r_ya, cmd_data[9:0], r_color};
                    end else begin
                        line_op <= {r_xa, r_ya, cmd_data[25:16], cmd_data[9:0], r_color};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
